// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline buffer, 32x32 register file with write-before-read bypass, retire counter.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite_MEM,
  input  logic             RPzero_MEM,
  input  logic             Valid_MEM,
  input  logic [4:0]       Rd_MEM,
  input  logic [31:0]      WBdata_MEM,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  output logic [31:0]      A_D,
  output logic [31:0]      B_D,
  output logic             RegWrite_WB,
  output logic             RPzero_WB,
  output logic [4:0]       Rd_WB,
  output logic [31:0]      WBvalue_WB,
  output logic [CNT_W-1:0] retired_count
);

  logic             regwrite_q, regwrite_d;
  logic             rpzero_q, rpzero_d;
  logic             valid_q, valid_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      wbdata_q, wbdata_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      rf_q [32];
  logic [31:0]      rf_d [32];
  logic             commit_we;

  assign commit_we = regwrite_q && !rpzero_q && (rd_q != 5'd0);

  always_comb begin
    regwrite_d = RegWrite_MEM;
    rpzero_d   = RPzero_MEM;
    valid_d    = Valid_MEM;
    rd_d       = Rd_MEM;
    wbdata_d   = WBdata_MEM;
    count_d    = count_q;
    for (int i = 0; i < 32; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (commit_we) begin
      rf_d[rd_q] = wbdata_q;
    end
    // Stores and branches retire too; only killed slots and bubbles are skipped.
    if (valid_q && !rpzero_q) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      rpzero_q   <= 1'b0;
      valid_q    <= 1'b0;
      rd_q       <= 5'd0;
      wbdata_q   <= 32'd0;
      count_q    <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      regwrite_q <= regwrite_d;
      rpzero_q   <= rpzero_d;
      valid_q    <= valid_d;
      rd_q       <= rd_d;
      wbdata_q   <= wbdata_d;
      count_q    <= count_d;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Bypass lets decode see the value committing this cycle without waiting an edge.
  always_comb begin
    A_D = rf_q[Rs_D];
    if (Rs_D == 5'd0) begin
      A_D = 32'd0;
    end else if (commit_we && (rd_q == Rs_D)) begin
      A_D = wbdata_q;
    end
  end

  always_comb begin
    B_D = rf_q[Rt_D];
    if (Rt_D == 5'd0) begin
      B_D = 32'd0;
    end else if (commit_we && (rd_q == Rt_D)) begin
      B_D = wbdata_q;
    end
  end

  assign RegWrite_WB   = regwrite_q;
  assign RPzero_WB     = rpzero_q;
  assign Rd_WB         = rd_q;
  assign WBvalue_WB    = wbdata_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage (CNT_W=4 to reach counter wrap).
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        RegWrite_MEM;
  logic        RPzero_MEM;
  logic        Valid_MEM;
  logic [4:0]  Rd_MEM;
  logic [31:0] WBdata_MEM;
  logic [4:0]  Rs_D;
  logic [4:0]  Rt_D;
  logic [31:0] A_D;
  logic [31:0] B_D;
  logic        RegWrite_WB;
  logic        RPzero_WB;
  logic [4:0]  Rd_WB;
  logic [31:0] WBvalue_WB;
  logic [3:0]  retired_count;

  int n_checks = 0;
  int n_pass   = 0;

  wb_stage #(.CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .RegWrite_MEM(RegWrite_MEM),
    .RPzero_MEM(RPzero_MEM),
    .Valid_MEM(Valid_MEM),
    .Rd_MEM(Rd_MEM),
    .WBdata_MEM(WBdata_MEM),
    .Rs_D(Rs_D),
    .Rt_D(Rt_D),
    .A_D(A_D),
    .B_D(B_D),
    .RegWrite_WB(RegWrite_WB),
    .RPzero_WB(RPzero_WB),
    .Rd_WB(Rd_WB),
    .WBvalue_WB(WBvalue_WB),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic rp, input logic v,
                       input logic [4:0] rd, input logic [31:0] data);
    RegWrite_MEM = rw;
    RPzero_MEM   = rp;
    Valid_MEM    = v;
    Rd_MEM       = rd;
    WBdata_MEM   = data;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bubble();
    Rs_D = 5'd0;
    Rt_D = 5'd0;
    #12;
    check("rst_regwrite", {31'd0, RegWrite_WB}, 32'd0);
    check("rst_rpzero", {31'd0, RPzero_WB}, 32'd0);
    check("rst_rd", {27'd0, Rd_WB}, 32'd0);
    check("rst_wbvalue", WBvalue_WB, 32'd0);
    check("rst_count", {28'd0, retired_count}, 32'd0);
    reset = 1'b0;

    // plain write to R3
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'd15);
    Rs_D = 5'd3;
    tick();
    check("wr_rd_wb", {27'd0, Rd_WB}, 32'd3);
    check("wr_wbvalue", WBvalue_WB, 32'd15);
    check("wr_regwrite", {31'd0, RegWrite_WB}, 32'd1);
    check("wr_bypass_a", A_D, 32'd15);
    check("wr_count_pre", {28'd0, retired_count}, 32'd0);
    bubble();
    tick();
    check("wr_rf_a", A_D, 32'd15);
    check("wr_count", {28'd0, retired_count}, 32'd1);

    // both read ports bypass the same committing register
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'hAAAA5555);
    Rs_D = 5'd4;
    Rt_D = 5'd4;
    tick();
    check("byp_a", A_D, 32'hAAAA5555);
    check("byp_b", B_D, 32'hAAAA5555);
    bubble();
    tick();
    check("byp_rf_b", B_D, 32'hAAAA5555);
    check("byp_count", {28'd0, retired_count}, 32'd2);

    // write aimed at R0
    drive(1'b1, 1'b0, 1'b1, 5'd0, 32'd99);
    Rs_D = 5'd0;
    Rt_D = 5'd0;
    tick();
    check("r0_a_inflight", A_D, 32'd0);
    bubble();
    tick();
    check("r0_a", A_D, 32'd0);
    check("r0_b", B_D, 32'd0);
    check("r0_count", {28'd0, retired_count}, 32'd3);

    // killed instruction
    drive(1'b1, 1'b1, 1'b1, 5'd5, 32'd7);
    Rs_D = 5'd5;
    tick();
    check("kill_rpzero", {31'd0, RPzero_WB}, 32'd1);
    check("kill_no_bypass", A_D, 32'd0);
    bubble();
    tick();
    check("kill_rpzero_gone", {31'd0, RPzero_WB}, 32'd0);
    check("kill_rf", A_D, 32'd0);
    check("kill_count", {28'd0, retired_count}, 32'd3);

    // back-to-back writes to R6
    drive(1'b1, 1'b0, 1'b1, 5'd6, 32'd1);
    Rs_D = 5'd6;
    tick();
    check("b2b_first", A_D, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 5'd6, 32'd2);
    tick();
    check("b2b_second", A_D, 32'd2);
    bubble();
    tick();
    check("b2b_final", A_D, 32'd2);
    check("b2b_count", {28'd0, retired_count}, 32'd5);

    // store-like: valid without RegWrite still retires
    drive(1'b0, 1'b0, 1'b1, 5'd7, 32'd55);
    Rs_D = 5'd7;
    tick();
    bubble();
    tick();
    check("store_rf", A_D, 32'd0);
    check("store_count", {28'd0, retired_count}, 32'd6);

    // ten more retirements take the 4-bit counter 6 -> 15 -> 0
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 5'd0, 32'd0);
      tick();
    end
    check("wrap_15", {28'd0, retired_count}, 32'd15);
    bubble();
    tick();
    check("wrap_0", {28'd0, retired_count}, 32'd0);

    // asynchronous reset between edges
    drive(1'b1, 1'b0, 1'b1, 5'd31, 32'd100);
    Rs_D = 5'd31;
    tick();
    bubble();
    tick();
    check("ar_pre_rf", A_D, 32'd100);
    check("ar_pre_count", {28'd0, retired_count}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 5'd8, 32'd9);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("ar_rf31", A_D, 32'd0);
    check("ar_count", {28'd0, retired_count}, 32'd0);
    check("ar_rd", {27'd0, Rd_WB}, 32'd0);
    check("ar_wbvalue", WBvalue_WB, 32'd0);
    check("ar_regwrite", {31'd0, RegWrite_WB}, 32'd0);
    tick();
    check("ar_held_rd", {27'd0, Rd_WB}, 32'd0);
    check("ar_held_rf31", A_D, 32'd0);
    reset = 1'b0;
    Rs_D = 5'd8;
    Rt_D = 5'd31;
    tick();
    check("rel_capture_rd", {27'd0, Rd_WB}, 32'd8);
    check("rel_capture_val", WBvalue_WB, 32'd9);
    check("rel_bypass", A_D, 32'd9);
    check("rel_rf31", B_D, 32'd0);
    check("rel_count", {28'd0, retired_count}, 32'd0);
    bubble();
    tick();
    check("rel_rf8", A_D, 32'd9);
    check("rel_count_after", {28'd0, retired_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of retire counter.
REQ-002 SHALL have port clk  input  1  single pipeline clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 SHALL have port RegWrite_MEM  input  1  register-write request from mem_stage.
REQ-005 SHALL have port RPzero_MEM  input  1  predicate-false/killed flag of the MEM instruction.
REQ-006 SHALL have port Valid_MEM  input  1  MEM slot holds a real instruction, not a bubble.
REQ-007 SHALL have port Rd_MEM  input  5  destination register index.
REQ-008 SHALL have port WBdata_MEM  input  32  value selected by mem_stage (ALU/load/NPC).
REQ-009 SHALL have ports Rs_D, Rt_D  input  5 each  decode-stage source indices.
REQ-010 SHALL have ports A_D, B_D  output  32 each  register-file read data for Rs_D, Rt_D.
REQ-011 SHALL have ports RegWrite_WB, RPzero_WB  output  1 each  buffered control, to Hazard_Unit.
REQ-012 SHALL have port Rd_WB  output  5  buffered destination, to Hazard_Unit.
REQ-013 SHALL have port WBvalue_WB  output  32  buffered writeback value, forwarding source.
REQ-014 SHALL have port retired_count  output  CNT_W  count of committed instructions.

Function
REQ-015 SHALL implement a MEM/WB buffer capturing RegWrite, RPzero, Valid, Rd, WBdata on every rising clk edge; no stall or kill input.
REQ-016 SHALL drive RegWrite_WB, RPzero_WB, Rd_WB, WBvalue_WB directly from the buffer (registered, 1-cycle latency from MEM inputs).
REQ-017 SHALL define commit_we = RegWrite_WB AND NOT RPzero_WB AND (Rd_WB != 0).
REQ-018 SHALL hold a 32x32 register file; on rising edge with commit_we, RF[Rd_WB] <= WBvalue_WB; total MEM-input-to-RF latency 2 edges.
REQ-019 SHALL never write R0; reads of index 0 SHALL return 0 regardless of any write.
REQ-020 SHALL read A_D/B_D combinationally: index 0 -> 0; else if commit_we and Rd_WB == index -> WBvalue_WB (write-before-read bypass); else RF[index].
REQ-021 SHALL apply REQ-020 independently per port; Rs_D == Rt_D == Rd_WB SHALL return WBvalue_WB on both.
REQ-022 SHALL increment retired_count on rising edge when buffered Valid AND NOT RPzero_WB; RegWrite not required (stores, branches count).
REQ-023 SHALL wrap retired_count from 2^CNT_W-1 to 0 without flag.
REQ-024 Killed instruction (RPzero_WB=1) SHALL neither write RF nor count, but SHALL still appear on WB outputs for one cycle.
REQ-025 Back-to-back writes to same Rd SHALL leave the later value; reads during each cycle SHALL see the value being committed that cycle.

Reset
REQ-026 While reset=1: all buffer outputs 0 (RegWrite_WB=0, RPzero_WB=0, Rd_WB=0, WBvalue_WB=0, Valid=0), all 32 RF entries 0, retired_count=0.
REQ-027 Reset asserted mid-operation SHALL discard the buffered instruction; no RF write SHALL occur on the edge coinciding with or following reset assertion while reset=1.
REQ-028 First edge after reset release SHALL capture MEM inputs normally; RF unchanged on that edge (buffer was cleared).

Verification
REQ-029 Write: RegWrite_MEM=1, Rd_MEM=3, WBdata_MEM=15, Valid=1 -> next edge Rd_WB=3, WBvalue_WB=15; following edge RF[3]=15, Rs_D=3 gives A_D=15, retired_count=1.
REQ-030 Bypass: while Rd_WB=4, WBvalue_WB=0xAAAA5555, commit_we=1, Rs_D=Rt_D=4 -> A_D=B_D=0xAAAA5555 in same cycle before RF update.
REQ-031 R0: RegWrite_MEM=1, Rd_MEM=0, WBdata_MEM=99 -> RF unchanged, A_D for Rs_D=0 stays 0, retired_count increments.
REQ-032 Predicate: RPzero_MEM=1, RegWrite_MEM=1, Rd_MEM=5, WBdata_MEM=7 -> RPzero_WB=1 for one cycle, RF[5] stays 0, retired_count unchanged.
REQ-033 Wrap: CNT_W=4, 16 valid non-killed instructions -> retired_count returns to 0.
REQ-034 Async reset: after RF[31]=100, assert reset between edges -> outputs, RF[31], retired_count read 0 immediately, before next clk edge.
